// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: IF fetch port, MEM load/store port, byte-wide RAM port.
// The slave modport is the controller's view. The master modport is the view of
// the surrounding pipeline and RAM.
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              flush;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [1:0]        mem_len;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_dout;
  logic [7:0]        ram_din;

  modport slave (
    input  flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_we, ram_dout
  );

  modport master (
    output flush, if_req, if_addr, mem_req, mem_we, mem_addr, mem_len, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_addr, ram_we, ram_dout
  );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: arbitrates the single byte-wide RAM port between instruction fetch
// and load/store. It splits word and halfword accesses into little-endian byte
// transactions.
// Optional build macro MEM_CTRL_PERF_EN adds three free-running performance
// counters:
//   - accepted IF accesses,
//   - accepted MEM accesses,
//   - IDLE cycles in which both requesters are eligible.
module mem_ctrl #(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MEM_CTRL_PERF_EN
  output logic [31:0] perf_if_cnt,
  output logic [31:0] perf_mem_cnt,
  output logic [31:0] perf_conflict_cnt,
`endif
  mem_ctrl_if.slave   bus
);

  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t            state_r, state_nxt_s;
  logic [2:0]        cnt_r;
  logic [2:0]        n_r;
  logic [31:0]       wdata_r;
  logic [31:0]       acc_r;
  logic [SW-1:0]     starve_r;
  logic [ADDR_W-1:0] ram_addr_r;
  logic              ram_we_r;
  logic [7:0]        ram_dout_r;
  logic              if_done_r;
  logic [31:0]       if_inst_r;
  logic              mem_done_r;
  logic [31:0]       mem_rdata_r;

  logic              if_elig_s, mem_elig_s, conflict_s, starved_s;
  logic              grant_if_s, grant_mem_s;
  logic [2:0]        mem_n_s;
  logic              last_s;
  logic [31:0]       assembled_s;

  // Pick byte idx[1:0] of a little-endian word
  function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [2:0] idx);
    logic [7:0] b;
    case (idx[1:0])
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      2'd3:    b = w[31:24];
      default: b = 8'd0;
    endcase
    return b;
  endfunction

  assign bus.ram_addr  = ram_addr_r;
  assign bus.ram_we    = ram_we_r;
  assign bus.ram_dout  = ram_dout_r;
  assign bus.if_done   = if_done_r;
  assign bus.if_inst   = if_inst_r;
  assign bus.mem_done  = mem_done_r;
  assign bus.mem_rdata = mem_rdata_r;

  // A requester completing this cycle is ignored so a held request does not
  // re-issue. Flush masks the fetch request.
  assign if_elig_s  = bus.if_req & ~bus.flush & ~if_done_r;
  assign mem_elig_s = bus.mem_req & ~mem_done_r;
  assign conflict_s = (state_r == IDLE) & if_elig_s & mem_elig_s;
  assign starved_s  = (STARVE_LIMIT != 0) && (starve_r == SW'(STARVE_LIMIT));
  assign last_s     = (cnt_r == n_r);

  // Arbitration: MEM has priority unless IF has lost STARVE_LIMIT conflicts in a row
  always_comb begin
    grant_if_s  = 1'b0;
    grant_mem_s = 1'b0;
    if (state_r == IDLE) begin
      if (conflict_s) begin
        if (starved_s) begin
          grant_if_s = 1'b1;
        end else begin
          grant_mem_s = 1'b1;
        end
      end else if (if_elig_s) begin
        grant_if_s = 1'b1;
      end else if (mem_elig_s) begin
        grant_mem_s = 1'b1;
      end else begin
        grant_if_s  = 1'b0;
        grant_mem_s = 1'b0;
      end
    end else begin
      grant_if_s  = 1'b0;
      grant_mem_s = 1'b0;
    end
  end

  // Map the load/store length code to a byte count; code 3 behaves as a word
  always_comb begin
    mem_n_s = 3'd4;
    case (bus.mem_len)
      2'd0:    mem_n_s = 3'd1;
      2'd1:    mem_n_s = 3'd2;
      default: mem_n_s = 3'd4;
    endcase
  end

  // Merge the byte on ram_din (read address issued cnt-1 steps ago) into the accumulator
  always_comb begin
    assembled_s = acc_r;
    case (cnt_r)
      3'd1:    assembled_s[7:0]   = bus.ram_din;
      3'd2:    assembled_s[15:8]  = bus.ram_din;
      3'd3:    assembled_s[23:16] = bus.ram_din;
      3'd4:    assembled_s[31:24] = bus.ram_din;
      default: assembled_s        = acc_r;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic: reads stay one cycle past the last address, to catch the final byte
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (grant_if_s) begin
          state_nxt_s = IF_RD;
        end else if (grant_mem_s) begin
          state_nxt_s = bus.mem_we ? MEM_WR : MEM_RD;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      IF_RD: begin
        if (bus.flush || last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = IF_RD;
        end
      end
      MEM_RD: begin
        if (last_s) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MEM_RD;
        end
      end
      MEM_WR: begin
        if (cnt_r == (n_r - 3'd1)) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = MEM_WR;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Datapath: RAM port sequencing, byte capture and completion pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r       <= 3'd0;
      n_r         <= 3'd0;
      wdata_r     <= 32'd0;
      acc_r       <= 32'd0;
      ram_addr_r  <= '0;
      ram_we_r    <= 1'b0;
      ram_dout_r  <= 8'd0;
      if_done_r   <= 1'b0;
      if_inst_r   <= 32'd0;
      mem_done_r  <= 1'b0;
      mem_rdata_r <= 32'd0;
    end else begin
      if_done_r  <= 1'b0;
      mem_done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_if_s) begin
            ram_addr_r <= bus.if_addr;
            ram_we_r   <= 1'b0;
            cnt_r      <= 3'd0;
            n_r        <= 3'd4;
            acc_r      <= 32'd0;
          end else if (grant_mem_s) begin
            ram_addr_r <= bus.mem_addr;
            ram_we_r   <= bus.mem_we;
            ram_dout_r <= bus.mem_we ? bus.mem_wdata[7:0] : ram_dout_r;
            wdata_r    <= bus.mem_wdata;
            cnt_r      <= 3'd0;
            n_r        <= mem_n_s;
            acc_r      <= 32'd0;
          end else begin
            ram_we_r <= 1'b0;
          end
        end
        IF_RD, MEM_RD: begin
          ram_we_r <= 1'b0;
          if ((state_r == IF_RD) && bus.flush) begin
            cnt_r <= 3'd0;
          end else if (last_s) begin
            if (state_r == IF_RD) begin
              if_done_r <= 1'b1;
              if_inst_r <= assembled_s;
            end else begin
              mem_done_r  <= 1'b1;
              mem_rdata_r <= assembled_s;
            end
          end else begin
            acc_r <= assembled_s;
            cnt_r <= cnt_r + 3'd1;
            if (cnt_r < (n_r - 3'd1)) begin
              ram_addr_r <= ram_addr_r + ADDR_W'(1);
            end else begin
              ram_addr_r <= ram_addr_r;
            end
          end
        end
        MEM_WR: begin
          if (cnt_r == (n_r - 3'd1)) begin
            ram_we_r   <= 1'b0;
            mem_done_r <= 1'b1;
          end else begin
            ram_we_r   <= 1'b1;
            ram_addr_r <= ram_addr_r + ADDR_W'(1);
            ram_dout_r <= byte_sel(wdata_r, cnt_r + 3'd1);
            cnt_r      <= cnt_r + 3'd1;
          end
        end
        default: begin
          ram_we_r <= 1'b0;
          cnt_r    <= 3'd0;
        end
      endcase
    end
  end

  // Starvation counter: counts IF conflict losses, cleared whenever IF is granted
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_r <= '0;
    end else if (grant_if_s) begin
      starve_r <= '0;
    end else if (conflict_s && grant_mem_s && (STARVE_LIMIT != 0)) begin
      starve_r <= starve_r + SW'(1);
    end else begin
      starve_r <= starve_r;
    end
  end

`ifdef MEM_CTRL_PERF_EN
  // Performance counters: accepted IF, accepted MEM, and contended IDLE cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_if_cnt       <= 32'd0;
      perf_mem_cnt      <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else begin
      perf_if_cnt       <= perf_if_cnt + {31'd0, grant_if_s};
      perf_mem_cnt      <= perf_mem_cnt + {31'd0, grant_mem_s};
      perf_conflict_cnt <= perf_conflict_cnt + {31'd0, conflict_s};
    end
  end
`else
  // Performance counters are not built in this configuration.
`endif

endmodule
